serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor computing a − b one bit per clock, LSB first, with a single registered borrow flip-flop. It is the inverse-direction companion to the team's combinational full adder: the same ripple cell, rebuilt sequentially as a borrow chain. The block sits in the arithmetic library as a minimal-area datapath element. A start/busy/done handshake launches each operation, and results are held until the next accepted start.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range ≥ 2

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- busy  output  1  high while state ≠ IDLE
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  a − b mod 2^WIDTH; held between operations
- borrow  output  1  final borrow; 1 iff a < b (unsigned)
- ovf  output  1  signed overflow; present only with SERIAL_SUBTRACTOR_OVF_EN

## Operation
- Three states: IDLE, RUN, DONE.
- IDLE → RUN on a clock edge with start = 1:
  - Latch a and b into shift registers.
  - Clear the borrow flip-flop and the bit counter.
- RUN, each edge, processes bit i using the LSB of each shift register:
  - d = a_i ^ b_i ^ br.
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - Shift d into a result shift register from the MSB side.
  - Shift the operand registers right.
  - Increment the counter.
- RUN → DONE on the edge that processes bit WIDTH−1. On that same edge:
  - Commit the result register to diff.
  - Commit the final br to borrow.
  - Commit ovf, if compiled in.
  - Set done = 1.
- DONE → IDLE unconditionally on the next edge; done returns to 0.
- Start is ignored in RUN and DONE and is not queued. A new start is accepted on the first edge back in IDLE.
- diff, borrow and ovf change only on the RUN → DONE edge, or on reset.
- Counter width is $clog2(WIDTH). It never wraps within a single operation.

## Timing
- All outputs reset to 0, and state resets to IDLE, immediately on rst assertion, independent of clk.
- Reset mid-RUN aborts the operation. No done pulse is produced. diff and borrow read 0.
- Latency: start sampled at edge 0 → done high in the cycle following edge WIDTH, i.e. WIDTH cycles after acceptance.
- busy rises after edge 0 and falls after edge WIDTH+1.
- Minimum start-to-start spacing: WIDTH+2 cycles.
- Operands may change freely after the accepted start edge. Inputs are not re-sampled.
- Deassertion of rst is assumed synchronous to clk upstream. The block adds no synchroniser.

## Configuration
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Port ovf exists.
  - ovf = (a[WIDTH−1] ≠ b[WIDTH−1]) & (diff[WIDTH−1] ≠ a[WIDTH−1]), evaluated on the original operand sign bits.
  - Those sign bits are latched at start.
  - ovf is committed with diff.
- Undefined:
  - No ovf port.
  - No sign-bit storage.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, a=10, b=3, start for 1 cycle → done pulse WIDTH cycles after acceptance; diff=7, borrow=0; busy high for 9 cycles.
- a=3, b=10 → diff=8'hF9, borrow=1; ovf=0 when the macro is defined.
- a=8'h80, b=8'h01 → diff=8'h7F, borrow=0; ovf=1 when the macro is defined. a=8'h7F, b=8'hFF → diff=8'h80, borrow=1, ovf=1.
- Corner operands:
  - a=0, b=0 → diff=0, borrow=0.
  - a=8'hFF, b=8'hFF → diff=0, borrow=0.
  - a=0, b=8'hFF → diff=8'h01, borrow=1.
- Start held high continuously, with a/b changed every cycle → only the values present at each accepted edge are used. Results are spaced exactly 10 cycles apart. No done pulse is lost or duplicated.
- rst asserted at RUN cycle 4 of a=10, b=3 → outputs are 0 immediately with no done pulse. After release, a fresh start produces the correct result (diff=7).

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first) with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned RW = WIDTH - 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [RW-1:0]    res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             br_q, br_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ai, bi, dbit, br_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             sa_q, sa_d, sb_q, sb_d, ovf_q, ovf_d;
`endif

   always_comb begin
      ai     = a_q[0];
      bi     = b_q[0];
      dbit   = ai ^ bi ^ br_q;
      br_nxt = (~ai & bi) | (~(ai ^ bi) & br_q);

      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      diff_d   = diff_q;
      br_d     = br_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      sa_d     = sa_q;
      sb_d     = sb_q;
      ovf_d    = ovf_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               a_d     = a;
               b_d     = b;
               br_d    = 1'b0;
               cnt_d   = '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               sa_d    = a[WIDTH-1];
               sb_d    = b[WIDTH-1];
`endif
            end
         end
         S_RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_nxt;
            // Result holds only WIDTH-1 bits; the final bit goes straight into diff.
            res_d = RW'({dbit, res_q} >> 1);
            if (cnt_q == LAST) begin
               state_d  = S_DONE;
               diff_d   = {dbit, res_q};
               borrow_d = br_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               ovf_d    = (sa_q ^ sb_q) & (dbit ^ sa_q);
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         br_q     <= 1'b0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         br_q     <= br_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); checks ovf when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      logic         ov;
      int unsigned  cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, borrow;
   logic [W-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic         ovf;
`endif

   int unsigned asserts = 0;
   int unsigned fails   = 0;
   int unsigned cyc     = 0;
   exp_t        sb_q[$];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
     ,.ovf    (ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expectation whenever done is seen.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("diff", diff, e.d);
            check("borrow", borrow, e.br);
            check("done_cycle", cyc, e.cyc);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            check("ovf", ovf, e.ov);
`endif
         end
      end
   end

   task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb,
                           input logic [W-1:0] ed, input logic ebr, input logic eov);
      exp_t e;
      e.d   = ed;
      e.br  = ebr;
      e.ov  = eov;
      e.cyc = cyc + W + 1;
      sb_q.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      int unsigned n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) check(name, 1, 0);
   endtask

   // One directed operation; also measures how many sampled cycles busy stays high.
   task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic ebr, input logic eov);
      int unsigned n = 0;
      wait_idle("idle_timeout");
      a = va;
      b = vb;
      start = 1'b1;
      push_exp(va, vb, ed, ebr, eov);
      @(negedge clk);
      start = 1'b0;
      a = ~va;
      b = va ^ vb;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", n, W + 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned prev_acc;
      bit          have_prev;
      logic [W-1:0] ta, tb_v, td;

      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_op(8'd10,  8'd3,   8'd7,   1'b0, 1'b0);
      do_op(8'd3,   8'd10,  8'hF9,  1'b1, 1'b0);
      do_op(8'h80,  8'h01,  8'h7F,  1'b0, 1'b1);
      do_op(8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1);
      do_op(8'h00,  8'h00,  8'h00,  1'b0, 1'b0);
      do_op(8'hFF,  8'hFF,  8'h00,  1'b0, 1'b0);
      do_op(8'h00,  8'hFF,  8'h01,  1'b1, 1'b0);
      do_op(8'h05,  8'h05,  8'h00,  1'b0, 1'b0);
      do_op(8'h55,  8'hAA,  8'hAB,  1'b1, 1'b1);

      // Start held high with operands changing every cycle.
      have_prev = 1'b0;
      prev_acc  = 0;
      start = 1'b1;
      for (int i = 0; i < 35; i++) begin
         ta   = W'(i * 37 + 5);
         tb_v = W'(i * 91 + 11);
         a = ta;
         b = tb_v;
         if (!busy) begin
            td = ta - tb_v;
            push_exp(ta, tb_v, td, (ta < tb_v), (ta[W-1] ^ tb_v[W-1]) & (td[W-1] ^ ta[W-1]));
            if (have_prev) check("accept_spacing", cyc - prev_acc, W + 2);
            prev_acc  = cyc;
            have_prev = 1'b1;
         end
         @(negedge clk);
      end
      start = 1'b0;
      wait_idle("burst_timeout");
      @(negedge clk);

      // Leave a non-zero result so the reset clear is observable.
      do_op(8'd3, 8'd10, 8'hF9, 1'b1, 1'b0);

      // Abort mid-RUN: no expectation is queued, so any done is flagged.
      a = 8'd10;
      b = 8'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_diff", diff, 0);
      check("abort_borrow", borrow, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check("abort_ovf", ovf, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_abort_busy", busy, 0);

      do_op(8'd10, 8'd3, 8'd7, 1'b0, 1'b0);

      repeat (20) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
